// File: rtl/rocc_acc_unit_if.sv
// rocc_acc_unit_if
//   RoCC command/response channel between the core (master) and the
//   accumulator accelerator (slave).
//   Command : cmd_funct[6:0], cmd_xd, cmd_rd[4:0], cmd_rs1, cmd_rs2,
//             cmd_valid (master->slave), cmd_ready (slave->master)
//   Response: resp_data, resp_rd[4:0], resp_valid (slave->master),
//             resp_ready (master->slave)
interface rocc_acc_unit_if #(
    parameter int XLEN = 64
);
    logic [6:0]      cmd_funct;
    logic            cmd_xd;
    logic [4:0]      cmd_rd;
    logic [XLEN-1:0] cmd_rs1;
    logic [XLEN-1:0] cmd_rs2;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [XLEN-1:0] resp_data;
    logic [4:0]      resp_rd;
    logic            resp_valid;
    logic            resp_ready;

    modport master (
        output cmd_funct, cmd_xd, cmd_rd, cmd_rs1, cmd_rs2, cmd_valid,
        input  cmd_ready,
        input  resp_data, resp_rd, resp_valid,
        output resp_ready
    );

    modport slave (
        input  cmd_funct, cmd_xd, cmd_rd, cmd_rs1, cmd_rs2, cmd_valid,
        output cmd_ready,
        output resp_data, resp_rd, resp_valid,
        input  resp_ready
    );
endinterface

// File: rtl/rocc_acc_unit.sv
// rocc_acc_unit
//   RoCC accumulator accelerator. Commands are buffered in an in-order FIFO
//   and executed on a bank of XLEN-bit accumulators (write, add, read,
//   clear-all, optional multiply-accumulate). A response {result, rd} is
//   returned only for commands with xd set, with valid/ready back-pressure.
//   Optional feature macro: ROCC_ACC_MAC_EN (adds MAC op, multiplier,
//   MAC_WAIT state and latency counter; without it op 4 is illegal).
// Ports
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   rocc    : rocc_acc_unit_if.slave command/response channel
//   busy_o  : FIFO non-empty or FSM not idle
//
// FSM states
//   state      | meaning
//   S_IDLE     | wait for FIFO non-empty, pop head into command register
//   S_EXEC     | decode and execute; MAC loads latency counter instead
//   S_MAC_WAIT | count down MAC latency, then commit MAC result
//   S_RESP     | hold response valid until the core accepts it
module rocc_acc_unit #(
    parameter int XLEN      = 64,
    parameter int NUM_ACC   = 4,
    parameter int CMD_DEPTH = 4,
    parameter int MAC_LAT   = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    rocc_acc_unit_if.slave       rocc,
    output logic                 busy_o
);
    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int IDX_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
    localparam logic [PTR_W:0] FULL_CNT    = (PTR_W+1)'(CMD_DEPTH);
    localparam logic [4:0]     NUM_ACC_L   = 5'(NUM_ACC);

    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_READ  = 3'd2;
    localparam logic [2:0] OP_CLEAR = 3'd3;
    localparam logic [2:0] OP_MAC   = 3'd4;

    typedef struct packed {
        logic [6:0]      funct;
        logic            xd;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1;
`ifdef ROCC_ACC_MAC_EN
        logic [XLEN-1:0] rs2;
`endif
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
`ifdef ROCC_ACC_MAC_EN
        S_MAC_WAIT,
`endif
        S_RESP
    } state_t;

    // ---------------- command FIFO ----------------
    cmd_t             fifo_mem_q [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push;
    logic             pop;
    cmd_t             cmd_in;

    // Ready is forced low during reset so nothing is pushed into a FIFO
    // whose pointers are being cleared.
    assign rocc.cmd_ready = !rst_i && (count_q != FULL_CNT);
    assign push           = rocc.cmd_valid && rocc.cmd_ready;

    always_comb begin
        cmd_in       = '0;
        cmd_in.funct = rocc.cmd_funct;
        cmd_in.xd    = rocc.cmd_xd;
        cmd_in.rd    = rocc.cmd_rd;
        cmd_in.rs1   = rocc.cmd_rs1;
`ifdef ROCC_ACC_MAC_EN
        cmd_in.rs2   = rocc.cmd_rs2;
`endif
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    // ---------------- execution FSM ----------------
    state_t          state_q, state_d;
    cmd_t            cmd_q, cmd_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      resp_rd_q, resp_rd_d;
    logic [XLEN-1:0] acc_q [NUM_ACC];
    logic [XLEN-1:0] acc_d [NUM_ACC];
`ifdef ROCC_ACC_MAC_EN
    localparam int CNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  mac_prod;
`endif

    logic [2:0]       op;
    logic [3:0]       idx;
    logic [IDX_W-1:0] sel;
    logic             idx_ok;
    logic             legal;
    logic             done;
    logic [XLEN-1:0]  acc_cur;

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        result_d  = result_q;
        resp_rd_d = resp_rd_q;
        acc_d     = acc_q;
        pop       = 1'b0;
        done      = 1'b0;
`ifdef ROCC_ACC_MAC_EN
        cnt_d     = cnt_q;
        mac_prod  = cmd_q.rs1 * cmd_q.rs2;
`endif

        op      = cmd_q.funct[2:0];
        idx     = cmd_q.funct[6:3];
        sel     = idx[IDX_W-1:0];
        idx_ok  = {1'b0, idx} < NUM_ACC_L;
        // acc_cur is only consumed when idx_ok holds
        acc_cur = acc_q[sel];

        case (op)
            OP_WRITE, OP_ADD, OP_READ: legal = idx_ok;
            OP_CLEAR:                  legal = 1'b1;
`ifdef ROCC_ACC_MAC_EN
            OP_MAC:                    legal = idx_ok;
`endif
            default:                   legal = 1'b0;
        endcase

        case (state_q)
            S_IDLE: begin
                // count_q is registered, so a command pushed this cycle is
                // not popped until the next one.
                if (count_q != '0) begin
                    pop     = 1'b1;
                    cmd_d   = fifo_mem_q[rd_ptr_q];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                resp_rd_d = cmd_q.rd;
                done      = 1'b1;
                if (!legal) begin
                    result_d = '1;
                end else begin
                    case (op)
                        OP_WRITE: begin
                            acc_d[sel] = cmd_q.rs1;
                            result_d   = cmd_q.rs1;
                        end
                        OP_ADD: begin
                            acc_d[sel] = acc_cur + cmd_q.rs1;
                            result_d   = acc_cur + cmd_q.rs1;
                        end
                        OP_READ: begin
                            result_d = acc_cur;
                        end
                        OP_CLEAR: begin
                            for (int i = 0; i < NUM_ACC; i++) begin
                                acc_d[i] = '0;
                            end
                            result_d = '0;
                        end
`ifdef ROCC_ACC_MAC_EN
                        OP_MAC: begin
                            done    = 1'b0;
                            cnt_d   = CNT_W'(MAC_LAT - 1);
                            state_d = S_MAC_WAIT;
                        end
`endif
                        default: begin
                            result_d = '1;
                        end
                    endcase
                end
            end
`ifdef ROCC_ACC_MAC_EN
            S_MAC_WAIT: begin
                if (cnt_q == '0) begin
                    acc_d[sel] = acc_cur + mac_prod;
                    result_d   = acc_cur + mac_prod;
                    done       = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            S_RESP: begin
                if (rocc.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (done) begin
            state_d = cmd_q.xd ? S_RESP : S_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            result_q  <= '0;
            resp_rd_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < NUM_ACC; i++) begin
                acc_q[i] <= '0;
            end
`ifdef ROCC_ACC_MAC_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            result_q  <= result_d;
            resp_rd_q <= resp_rd_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
`ifdef ROCC_ACC_MAC_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign rocc.resp_valid = (state_q == S_RESP);
    assign rocc.resp_data  = result_q;
    assign rocc.resp_rd    = resp_rd_q;
    assign busy_o          = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_rocc_acc_unit.sv
module tb_rocc_acc_unit;
    localparam int XLEN      = 64;
    localparam int NUM_ACC   = 4;
    localparam int CMD_DEPTH = 4;
    localparam int MAC_LAT   = 3;
`ifdef ROCC_ACC_MAC_EN
    localparam bit MAC_ON = 1'b1;
`else
    localparam bit MAC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    always #5 clk = ~clk;

    rocc_acc_unit_if #(.XLEN(XLEN)) rocc ();

    rocc_acc_unit #(
        .XLEN(XLEN), .NUM_ACC(NUM_ACC), .CMD_DEPTH(CMD_DEPTH), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .rocc  (rocc),
        .busy_o(busy)
    );

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] m_acc [NUM_ACC];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          rdy_mode = 1;   // 0 low, 1 high, 2 random

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [6:0] fn(input int idx, input int op);
        logic [3:0] i4;
        logic [2:0] o3;
        i4 = idx[3:0];
        o3 = op[2:0];
        return {i4, o3};
    endfunction

    // Reference model: applies a command's architectural effect and returns its result.
    function automatic logic [63:0] model_exec(input logic [6:0] funct,
                                               input logic [63:0] rs1,
                                               input logic [63:0] rs2);
        int op;
        int idx;
        logic [63:0] prod;
        op  = int'(funct[2:0]);
        idx = int'(funct[6:3]);
        if (op == 3) begin
            for (int i = 0; i < NUM_ACC; i++) m_acc[i] = 64'd0;
            return 64'd0;
        end
        if (op > 4 || idx >= NUM_ACC) return '1;
        case (op)
            0: m_acc[idx] = rs1;
            1: m_acc[idx] = m_acc[idx] + rs1;
            2: ;
            default: begin
                if (!MAC_ON) return '1;
                prod = rs1 * rs2;
                m_acc[idx] = m_acc[idx] + prod;
            end
        endcase
        return m_acc[idx];
    endfunction

    task automatic send(input logic [6:0] funct, input logic xd, input logic [4:0] rd,
                        input logic [63:0] rs1, input logic [63:0] rs2, input bit track);
        int guard;
        logic [63:0] r;
        exp_t e;
        rocc.cmd_funct = funct;
        rocc.cmd_xd    = xd;
        rocc.cmd_rd    = rd;
        rocc.cmd_rs1   = rs1;
        rocc.cmd_rs2   = rs2;
        rocc.cmd_valid = 1'b1;
        guard = 0;
        while (!rocc.cmd_ready && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!rocc.cmd_ready) begin
            n_checks++;
            $display("FAIL cmd_accept_timeout: cmd_ready stayed 0, required 1");
            rocc.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        rocc.cmd_valid = 1'b0;
        if (track) begin
            r = model_exec(funct, rs1, rs2);
            if (xd) begin
                e.data = r;
                e.rd   = rd;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int guard;
        guard = 0;
        while (!(exp_q.size() == 0 && !busy) && guard < budget) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!(exp_q.size() == 0 && !busy)) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d responses outstanding, busy=%0b, required 0/0",
                     exp_q.size(), busy);
        end
    endtask

    // resp_ready driver
    initial begin
        rocc.resp_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                0:       rocc.resp_ready = 1'b0;
                1:       rocc.resp_ready = 1'b1;
                default: rocc.resp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Response monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rocc.resp_valid && rocc.resp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_resp: got data %h rd %0d, required no response",
                             rocc.resp_data, rocc.resp_rd);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_data", rocc.resp_data, e.data);
                    chk("resp_rd", 64'(rocc.resp_rd), 64'(e.rd));
                end
            end
        end
    end

    initial begin
        int lat;
        logic [63:0] head;
        rocc.cmd_valid = 1'b0;
        rocc.cmd_funct = '0;
        rocc.cmd_xd    = 1'b0;
        rocc.cmd_rd    = '0;
        rocc.cmd_rs1   = '0;
        rocc.cmd_rs2   = '0;
        for (int i = 0; i < NUM_ACC; i++) m_acc[i] = 64'd0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(rocc.cmd_ready), 64'd0);
        chk("rst_resp_valid", 64'(rocc.resp_valid), 64'd0);
        chk("rst_resp_data", rocc.resp_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_cmd_ready", 64'(rocc.cmd_ready), 64'd1);

        // WRITE with response latency
        send(fn(1, 0), 1'b1, 5'd9, 64'd5, 64'd0, 1'b1);
        @(posedge clk); #1;
        chk("lat_write_early", 64'(rocc.resp_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_write_valid", 64'(rocc.resp_valid), 64'd1);
        wait_idle(100);

        // ADD without response then READ
        send(fn(1, 1), 1'b0, 5'd0, 64'd3, 64'd0, 1'b1);
        send(fn(1, 2), 1'b1, 5'd10, 64'd0, 64'd0, 1'b1);
        wait_idle(100);

        // ADD wrap
        send(fn(0, 0), 1'b0, 5'd0, '1, 64'd0, 1'b1);
        send(fn(0, 1), 1'b1, 5'd3, 64'd1, 64'd0, 1'b1);
        wait_idle(100);

        // back-pressure: five commands with response ready low
        rdy_mode = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++)
            send(fn(i % NUM_ACC, (i % 2 == 0) ? 1 : 2), 1'b1, 5'(11 + i),
                 64'(100 + i), 64'd0, 1'b1);
        chk("full_cmd_ready", 64'(rocc.cmd_ready), 64'd0);
        chk("full_busy", 64'(busy), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        head = exp_q[0].data;
        chk("hold_valid", 64'(rocc.resp_valid), 64'd1);
        chk("hold_data", rocc.resp_data, head);
        chk("hold_cmd_ready", 64'(rocc.cmd_ready), 64'd0);
        rdy_mode = 1;
        wait_idle(200);

        // MAC (or illegal op 4 without the feature)
        send(fn(2, 0), 1'b0, 5'd0, 64'd1, 64'd0, 1'b1);
        wait_idle(100);
        send(fn(2, 4), 1'b1, 5'd4, 64'd6, 64'd7, 1'b1);
        lat = MAC_ON ? 3 + MAC_LAT : 3;
        for (int e = 2; e <= lat; e++) begin
            @(posedge clk); #1;
            if (e == lat - 1) chk("lat_mac_early", 64'(rocc.resp_valid), 64'd0);
            if (e == lat)     chk("lat_mac_valid", 64'(rocc.resp_valid), 64'd1);
        end
        wait_idle(100);
        send(fn(2, 2), 1'b1, 5'd6, 64'd0, 64'd0, 1'b1);
        wait_idle(100);

        // illegal op and index, then read back all accumulators
        send(fn(0, 6), 1'b1, 5'd5, 64'd77, 64'd0, 1'b1);
        send(fn(7, 0), 1'b1, 5'd8, 64'd123, 64'd0, 1'b1);
        send(fn(9, 1), 1'b1, 5'd12, 64'd1, 64'd0, 1'b1);
        for (int i = 0; i < NUM_ACC; i++)
            send(fn(i, 2), 1'b1, 5'(20 + i), 64'd0, 64'd0, 1'b1);
        wait_idle(200);

        // reset while a response-bearing MAC is in flight
        send(fn(1, 0), 1'b0, 5'd0, 64'd55, 64'd0, 1'b1);
        wait_idle(100);
        rdy_mode = 0;
        @(posedge clk); #1;
        send(fn(1, 4), 1'b1, 5'd2, 64'd2, 64'd3, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", 64'(rocc.resp_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < NUM_ACC; i++) m_acc[i] = 64'd0;
        rdy_mode = 1;
        @(posedge clk); #1;
        chk("postrst_valid", 64'(rocc.resp_valid), 64'd0);
        send(fn(1, 2), 1'b1, 5'd7, 64'd0, 64'd0, 1'b1);
        wait_idle(100);

        // randomized traffic with random response back-pressure
        rdy_mode = 2;
        for (int n = 0; n < 80; n++) begin
            int op;
            int idx;
            op  = (($urandom_range(0, 9)) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
            idx = int'($urandom_range(0, NUM_ACC));
            send(fn(idx, op), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)}, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        rdy_mode = 1;
        wait_idle(3000);
        for (int i = 0; i < NUM_ACC; i++)
            send(fn(i, 2), 1'b1, 5'(i), 64'd0, 64'd0, 1'b1);
        wait_idle(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
